// File: rtl/uart_tx_arb_pkg.sv
// Shared types and widths for the UART TX byte-channel arbiter.
// Optional stall timeout is enabled with UART_TX_ARB_TIMEOUT_EN.
package uart_tx_arb_pkg;

  localparam int BYTE_W          = 8;
  localparam int NUM_REQ_DEFAULT = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } arb_state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ID_W = id_width(NUM_REQ_DEFAULT);

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after rr_ptr, with wrap.
module rr_picker
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     rr_ptr,
  output logic [IDW-1:0]     winner,
  output logic               any_valid
);

  logic [NUM_REQ-1:0] hit;
  logic [IDW-1:0]     idx [NUM_REQ];

  // idx[gi] is the requester sitting gi places after rr_ptr (rr_ptr < NUM_REQ, so one wrap is enough)
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_off
    logic [IDW:0] sum;
    assign sum     = {1'b0, rr_ptr} + (IDW+1)'(gi);
    assign idx[gi] = (sum >= (IDW+1)'(NUM_REQ)) ? IDW'(sum - (IDW+1)'(NUM_REQ)) : sum[IDW-1:0];
    assign hit[gi] = req[idx[gi]];
  end

  always_comb begin
    winner    = idx[0];
    any_valid = |hit;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (hit[k]) winner = idx[k];
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one uart_tx byte channel; paces bytes off tx_busy.
// Define UART_TX_ARB_TIMEOUT_EN to revoke a lock stalled mid-packet for TIMEOUT_CYCLES.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int BUSY_WAIT      = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [BYTE_W-1:0]           tx_data,
  output logic                        tx_start,
  input  logic                        tx_busy,
  output logic                        grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        err_timeout
);

  localparam int IDW   = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BUSY_WAIT + 1);

  arb_state_e          state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                last_q;
  logic [BYTE_W-1:0]   tx_data_q;
  logic                tx_start_q;
  logic [NUM_REQ-1:0]  req_ready_q;
  logic                grant_valid_q;
  logic [IDW-1:0]      grant_id_q;
  logic [IDW-1:0]      rr_ptr_q;

  logic [IDW-1:0]      winner;
  logic                any_valid;
  logic                holder_valid;
  logic [BYTE_W-1:0]   holder_byte;
  logic                holder_last;
  logic [IDW-1:0]      rr_next_d;
  logic                stall_hit;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_picker (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_q),
    .winner    (winner),
    .any_valid (any_valid)
  );

  assign holder_valid = req_valid[grant_id_q];
  assign holder_byte  = req_data[grant_id_q*BYTE_W +: BYTE_W];
  assign holder_last  = req_last[grant_id_q];
  assign rr_next_d    = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDW-1:0] id);
    onehot = NUM_REQ'(1) << id;
  endfunction

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [STALL_W-1:0] stall_q;
  logic               err_q;

  assign stall_hit = (state_q == LOAD) && !holder_valid &&
                     (stall_q == STALL_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state_q != LOAD || holder_valid || stall_hit) stall_q <= '0;
      else                                              stall_q <= stall_q + 1'b1;
      if (stall_hit) err_q <= 1'b1;
    end
  end

  assign err_timeout = err_q;
`else
  assign stall_hit   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      last_q        <= 1'b0;
      tx_data_q     <= '0;
      tx_start_q    <= 1'b0;
      req_ready_q   <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      rr_ptr_q      <= '0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Never grant while a byte (possibly from before reset) is still on the wire
          if (!tx_busy && any_valid) begin
            grant_id_q    <= winner;
            grant_valid_q <= 1'b1;
            req_ready_q   <= onehot(winner);
            state_q       <= LOAD;
          end
        end
        LOAD: begin
          if (holder_valid) begin
            tx_data_q   <= holder_byte;
            last_q      <= holder_last;
            tx_start_q  <= 1'b1;
            req_ready_q <= '0;
            cnt_q       <= '0;
            state_q     <= WAIT_HI;
          end else if (stall_hit) begin
            grant_valid_q <= 1'b0;
            rr_ptr_q      <= rr_next_d;
            req_ready_q   <= '0;
            state_q       <= IDLE;
          end
        end
        WAIT_HI: begin
          if (tx_busy || cnt_q == CNT_W'(BUSY_WAIT - 1)) state_q <= WAIT_LO;
          else                                           cnt_q   <= cnt_q + 1'b1;
        end
        WAIT_LO: begin
          if (!tx_busy) begin
            if (last_q) begin
              grant_valid_q <= 1'b0;
              rr_ptr_q      <= rr_next_d;
              state_q       <= IDLE;
            end else begin
              req_ready_q <= onehot(grant_id_q);
              state_q     <= LOAD;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: IDLE-grant vector table, packet-level round-robin
// reference model over random packets, plus reset / no-busy / stall sequences.
module tb_uart_tx_arbiter;

  localparam int N = 3;
`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1_000_000;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0] req_last;
  logic [N-1:0] req_ready;
  logic [7:0]   tx_data;
  logic         tx_start;
  logic         tx_busy;
  logic         grant_valid;
  logic [1:0]   grant_id;
  logic         err_timeout;

  uart_tx_arbiter #(
    .NUM_REQ        (N),
    .BUSY_WAIT      (4),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Requester sources: {last, byte} entries consumed on valid&ready
  logic [8:0] src_mem [N][64];
  int         src_len [N];
  int         src_head[N];
  bit         auto_mode;

  // uart_tx model: busy rises 2 cycles after start, stays 10 cycles; mode 1 never goes busy
  int uart_mode;
  int m_dly;
  int m_bcnt;

  logic [7:0] obs_data[512];
  int         obs_id  [512];
  int         obs_cyc [512];
  int         obs_n;
  int         cyc;

  typedef struct {
    logic [2:0] valid;
    logic       busy;
    logic       exp_gv;
    logic [1:0] exp_id;
    logic [2:0] exp_rdy;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive();
    if (!auto_mode) return;
    for (int i = 0; i < N; i++) begin
      if (src_head[i] < src_len[i]) begin
        req_valid[i]        = 1'b1;
        req_data[i*8 +: 8]  = src_mem[i][src_head[i]][7:0];
        req_last[i]         = src_mem[i][src_head[i]][8];
      end else begin
        req_valid[i]        = 1'b0;
        req_data[i*8 +: 8]  = 8'h00;
        req_last[i]         = 1'b0;
      end
    end
  endtask

  task automatic step();
    logic [N-1:0] hs;
    logic         st;
    hs = req_valid & req_ready;
    st = tx_start;
    @(posedge clk);
    #1;
    cyc++;
    if (auto_mode) begin
      for (int i = 0; i < N; i++) if (hs[i]) src_head[i]++;
    end
    if (m_dly > 0) begin
      m_dly--;
      if (m_dly == 0) begin
        tx_busy = 1'b1;
        m_bcnt  = 10;
      end
    end else if (tx_busy) begin
      m_bcnt--;
      if (m_bcnt == 0) tx_busy = 1'b0;
    end
    if (st && uart_mode == 0) m_dly = 2;
    drive();
    if (tx_start && obs_n < 512) begin
      obs_data[obs_n] = tx_data;
      obs_id[obs_n]   = int'(grant_id);
      obs_cyc[obs_n]  = cyc;
      obs_n++;
      $display("tx cyc=%0d id=%0d data=%02h", cyc, grant_id, tx_data);
    end
  endtask

  task automatic push(input int r, input logic [8:0] v);
    src_mem[r][src_len[r]] = v;
    src_len[r]++;
  endtask

  task automatic reset_dut();
    auto_mode = 1'b0;
    uart_mode = 0;
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_busy   = 1'b0;
    m_dly     = 0;
    m_bcnt    = 0;
    for (int i = 0; i < N; i++) begin
      src_len[i]  = 0;
      src_head[i] = 0;
    end
    step();
    step();
    rst   = 1'b0;
    obs_n = 0;
  endtask

  task automatic run_until_done(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      step();
      done = !grant_valid && !tx_busy && m_dly == 0;
      for (int i = 0; i < N; i++) if (src_head[i] != src_len[i]) done = 1'b0;
    end
    check({name, "_done"}, 32'(done), 32'd1);
  endtask

  // Packet-level reference: every source stays valid while it has data, so each arbitration
  // picks the first non-empty source at or after the pointer, which then moves past the winner.
  task automatic check_stream(input string name);
    logic [7:0] exp_d [512];
    int         exp_id[512];
    int         hd[N];
    int         n, p, r;
    bit         last;
    n = 0;
    p = 0;
    for (int i = 0; i < N; i++) hd[i] = 0;
    for (int guard = 0; guard < 64; guard++) begin
      r = -1;
      for (int k = N - 1; k >= 0; k--) if (hd[(p + k) % N] < src_len[(p + k) % N]) r = (p + k) % N;
      if (r < 0) break;
      last = 1'b0;
      while (!last && hd[r] < src_len[r]) begin
        exp_d[n]  = src_mem[r][hd[r]][7:0];
        exp_id[n] = r;
        last      = src_mem[r][hd[r]][8];
        hd[r]++;
        n++;
      end
      p = (r + 1) % N;
    end
    check({name, "_count"}, 32'(obs_n), 32'(n));
    for (int k = 0; k < n && k < obs_n; k++) begin
      check({name, "_data"}, 32'(obs_data[k]), 32'(exp_d[k]));
      check({name, "_id"}, 32'(obs_id[k]), 32'(exp_id[k]));
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bad;
    bit seen;
    int n2;
    cyc = 0;
    obs_n = 0;

    vecs[0] = '{3'b000, 1'b0, 1'b0, 2'd0, 3'b000};
    vecs[1] = '{3'b010, 1'b0, 1'b1, 2'd1, 3'b010};
    vecs[2] = '{3'b110, 1'b0, 1'b1, 2'd1, 3'b010};
    vecs[3] = '{3'b101, 1'b0, 1'b1, 2'd0, 3'b001};
    vecs[4] = '{3'b100, 1'b0, 1'b1, 2'd2, 3'b100};
    vecs[5] = '{3'b111, 1'b1, 1'b0, 2'd0, 3'b000};
    vecs[6] = '{3'b111, 1'b0, 1'b1, 2'd0, 3'b001};

    // Reset state
    reset_dut();
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_grant_valid", 32'(grant_valid), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_err_timeout", 32'(err_timeout), 32'd0);

    // IDLE arbitration table (rr_ptr = 0 after reset)
    for (int v = 0; v < 7; v++) begin
      reset_dut();
      req_valid = vecs[v].valid;
      tx_busy   = vecs[v].busy;
      m_bcnt    = 50;
      step();
      check("vec_grant_valid", 32'(grant_valid), 32'(vecs[v].exp_gv));
      check("vec_req_ready", 32'(req_ready), 32'(vecs[v].exp_rdy));
      if (vecs[v].exp_gv) check("vec_grant_id", 32'(grant_id), 32'(vecs[v].exp_id));
    end

    // Requester 1 single packet, then the pointer must sit at 2
    reset_dut();
    push(1, 9'h041);
    push(1, 9'h042);
    push(1, 9'h10A);
    auto_mode = 1'b1;
    drive();
    run_until_done("pkt1", 400);
    check_stream("pkt1");
    auto_mode = 1'b0;
    req_valid = 3'b111;
    step();
    check("ptr_after_pkt1_gv", 32'(grant_valid), 32'd1);
    check("ptr_after_pkt1_id", 32'(grant_id), 32'd2);
    check("grant_id_hold", 32'(obs_id[0]), 32'd1);

    // All requesters with 2-byte packets: order 0,1,2,0
    reset_dut();
    push(0, 9'h0A0); push(0, 9'h1A1); push(0, 9'h0A2); push(0, 9'h1A3);
    push(1, 9'h0B0); push(1, 9'h1B1);
    push(2, 9'h0C0); push(2, 9'h1C1);
    auto_mode = 1'b1;
    drive();
    run_until_done("rot", 1000);
    check_stream("rot");

    // uart_tx that never raises busy: byte spacing is 4 WAIT_HI + WAIT_LO + LOAD
    reset_dut();
    uart_mode = 1;
    push(0, 9'h031); push(0, 9'h032); push(0, 9'h133);
    auto_mode = 1'b1;
    drive();
    run_until_done("nobusy", 200);
    check_stream("nobusy");
    if (obs_n >= 3) begin
      check("nobusy_gap1", 32'(obs_cyc[1] - obs_cyc[0]), 32'd6);
      check("nobusy_gap2", 32'(obs_cyc[2] - obs_cyc[1]), 32'd6);
    end else begin
      check("nobusy_bytes", 32'(obs_n), 32'd3);
    end

    // Randomized packets against the reference model
    for (int round = 0; round < 4; round++) begin
      reset_dut();
      for (int r = 0; r < N; r++) begin
        int npk;
        npk = $urandom_range(0, 2);
        for (int p = 0; p < npk; p++) begin
          int len;
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) push(r, {(b == len - 1), 8'($urandom)});
        end
      end
      auto_mode = 1'b1;
      drive();
      run_until_done("rand", 3000);
      check_stream("rand");
    end

    // Reset while byte 2 of 3 is on the wire
    reset_dut();
    push(0, 9'h011); push(0, 9'h012); push(0, 9'h113);
    auto_mode = 1'b1;
    drive();
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      step();
      seen = (obs_n == 2) && tx_busy;
    end
    check("rstmid_reached", 32'(seen), 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstmid_tx_start", 32'(tx_start), 32'd0);
    check("rstmid_tx_data", 32'(tx_data), 32'd0);
    check("rstmid_req_ready", 32'(req_ready), 32'd0);
    check("rstmid_grant_valid", 32'(grant_valid), 32'd0);
    check("rstmid_grant_id", 32'(grant_id), 32'd0);
    check("rstmid_busy_still", 32'(tx_busy), 32'd1);
    bad = 1'b0;
    for (int c = 0; c < 40 && tx_busy; c++) begin
      step();
      if (grant_valid) bad = 1'b1;
    end
    check("rstmid_no_grant_busy", 32'(bad), 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 5 && !seen; c++) begin
      step();
      seen = grant_valid;
    end
    check("rstmid_regrant", 32'(seen), 32'd1);
    check("rstmid_regrant_id", 32'(grant_id), 32'd0);

    // Holder stalls mid-packet while requester 2 waits
    reset_dut();
    push(0, 9'h021);
    push(2, 9'h1C1);
    auto_mode = 1'b1;
    drive();
    for (int c = 0; c < 200; c++) step();
    n2 = 0;
    for (int k = 0; k < obs_n; k++) if (obs_id[k] == 2) n2++;
`ifdef UART_TX_ARB_TIMEOUT_EN
    check("stall_err", 32'(err_timeout), 32'd1);
    check("stall_req2_bytes", 32'(n2), 32'd1);
    check("stall_total", 32'(obs_n), 32'd2);
`else
    check("stall_err", 32'(err_timeout), 32'd0);
    check("stall_req2_bytes", 32'(n2), 32'd0);
    check("stall_lock_held", 32'(grant_valid), 32'd1);
    check("stall_holder", 32'(grant_id), 32'd0);
    check("stall_ready", 32'(req_ready), 32'b001);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART TX byte channel (tx_data / tx_start / tx_busy into uart_tx) between NUM_REQ byte-stream requesters, e.g. result printer, error reporter and command echo inside system_top.
- Uses round-robin arbitration with packet lock: a granted requester keeps the channel until its byte marked last has been fully sent.
- Paces bytes off tx_busy, so a requester never needs to know UART timing.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- BUSY_WAIT, 4, maximum cycles after tx_start to wait for tx_busy to rise before treating the byte as already taken.
- TIMEOUT_CYCLES, 1_000_000, mid-packet stall limit (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  byte of requester i at bits [8i+7:8i].
- req_last  in  NUM_REQ  byte is the final byte of the packet.
- req_ready  out  NUM_REQ  byte accepted when valid and ready are both high.
- tx_data  out  8  byte to uart_tx.
- tx_start  out  1  one-cycle start pulse to uart_tx.
- tx_busy  in  1  uart_tx busy.
- grant_valid  out  1  a requester holds the lock.
- grant_id  out  clog2(NUM_REQ)  current or last holder.
- err_timeout  out  1  sticky stall flag (optional feature only; otherwise tied to 0).

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE, tx_start=0, tx_data=0, req_ready=0, grant_valid=0, grant_id=0, rr_ptr=0, err_timeout=0.
- Reset mid-byte or mid-packet aborts the lock immediately. The partial packet is lost; no replay.
- IDLE: if tx_busy=0 and any req_valid is high, pick the winner as the first valid index scanning from rr_ptr upward with wrap. Register grant_id=winner and grant_valid=1, then go to LOAD.
  - IDLE never grants while tx_busy=1. This covers a byte still in flight after reset.
- LOAD: req_ready[grant_id]=1 and all other ready bits are 0. req_ready is registered and equals (next state == LOAD).
  - On req_valid[grant_id]: capture tx_data=byte and last_q=req_last; pulse tx_start=1 for exactly the next cycle; go to WAIT_HI.
  - Without req_valid: stay in LOAD with the lock held.
- WAIT_HI: cnt increments from 0. Go to WAIT_LO when tx_busy=1 or when cnt==BUSY_WAIT-1.
- WAIT_LO: on tx_busy=0:
  - if last_q: grant_valid=0, rr_ptr=(grant_id+1) mod NUM_REQ, go to IDLE;
  - else go to LOAD.
- Latency: req_valid in IDLE gives req_ready 1 cycle later. Acceptance gives tx_start on the next cycle. Back-to-back bytes inside a packet need one LOAD cycle after tx_busy falls.
- Fairness: a requester that just finished has lowest priority on the next arbitration. With all requesters valid, grants rotate 0,1,2,0,...
- Requests from non-holders are ignored and never acknowledged during a lock.
- req_last on a single-byte packet releases the lock after that byte.
- grant_id holds its value after release.
- A requester dropping valid mid-packet stalls the channel; see the optional feature.

Optional Feature:
- Macro: UART_TX_ARB_TIMEOUT_EN.
- Defined:
  - a stall counter runs while in LOAD with req_valid[grant_id]=0 and resets on acceptance;
  - at TIMEOUT_CYCLES the lock is revoked exactly as a last-byte release (rr_ptr advances), err_timeout is set and stays set until rst, and the state goes to IDLE.
- Undefined: no counter logic; err_timeout is tied to 0; the lock is held indefinitely.

Decomposition:
- Package uart_tx_arb_pkg holds:
  - state encoding: IDLE, LOAD, WAIT_HI, WAIT_LO;
  - ID_W = clog2(NUM_REQ);
  - BYTE_W = 8.
- Sub-module rr_picker is combinational. Inputs: req vector and rr_ptr. Outputs: winner index and any_valid.

Test Plan:
- Requester 1 sends one packet 0x41,0x42,0x0A (last on 0x0A) with a uart_tx model (busy 2 cycles after start, 10 cycles long) -> exactly three tx_start pulses carrying 0x41, 0x42, 0x0A in order; grant_valid falls after tx_busy falls; rr_ptr=2.
- All three requesters hold 2-byte packets continuously -> packet order on tx_data is req0, req1, req2, req0; bytes are never interleaved inside a packet.
- A uart_tx model that never raises tx_busy -> WAIT_HI exits after 4 cycles and the next byte follows; no hang.
- Assert rst in WAIT_LO of byte 2 of 3 while tx_busy=1 -> all outputs return to reset values next cycle; a new grant is issued only after tx_busy=0.
- With UART_TX_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: req0 drops valid after byte 1 while req2 waits -> lock is revoked at 16 idle cycles, err_timeout=1, req2 is granted next. Without the macro: req2 is never granted and err_timeout stays 0.
